// File: rtl/dp_ram_false_sync_read.sv
// Dual-port flop RAM: port A read/write, port B read-only.
// Both read ports are registered and read-before-write.
module dp_ram_false_sync_read #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] a,
    input  logic [ADDR_WIDTH-1:0] dpra,
    input  logic [DATA_WIDTH-1:0] di,
    output logic [DATA_WIDTH-1:0] spo,
    output logic [DATA_WIDTH-1:0] dpo
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Reads sample mem before this edge's write lands, so no bypass exists.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            spo <= '0;
            dpo <= '0;
        end else begin
            if (we) begin
                mem[a] <= di;
            end
            spo <= mem[a];
            dpo <= mem[dpra];
        end
    end

endmodule

// File: tb/tb_dp_ram_false_sync_read.sv
// Directed self-checking bench for dp_ram_false_sync_read.
module tb_dp_ram_false_sync_read;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       we = 1'b0;
    logic [4:0] a = '0;
    logic [4:0] dpra = '0;
    logic [3:0] di = '0;
    logic [3:0] spo;
    logic [3:0] dpo;

    int n_checks = 0;
    int n_fail = 0;

    dp_ram_false_sync_read dut (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (we),
        .a    (a),
        .dpra (dpra),
        .di   (di),
        .spo  (spo),
        .dpo  (dpo)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        we = 1'b1; a = 5'd4; di = 4'hB;
        tick();
        we = 1'b0; a = 5'd4; dpra = 5'd4;
        tick();
        n_checks++;
        if (spo !== 4'hB || dpo !== 4'hB) begin
            n_fail++;
            $display("FAIL pre_reset_data spo=%h dpo=%h required B/B", spo, dpo);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (spo !== 4'h0 || dpo !== 4'h0) begin
            n_fail++;
            $display("FAIL async_reset spo=%h dpo=%h required 0/0", spo, dpo);
        end
        #1 rst_n = 1'b1;
        a = 5'd0; dpra = 5'd31;
        tick();
        n_checks++;
        if (spo !== 4'h0 || dpo !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_read_0_31 spo=%h dpo=%h required 0/0", spo, dpo);
        end
        a = 5'd31; dpra = 5'd4;
        tick();
        n_checks++;
        if (spo !== 4'h0 || dpo !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_read_31_4 spo=%h dpo=%h required 0/0", spo, dpo);
        end
    endtask

    task automatic test_write_read;
        we = 1'b1; a = 5'd1; di = 4'hA;
        tick();
        a = 5'd2; di = 4'hC;
        tick();
        we = 1'b0; dpra = 5'd2;
        tick();
        n_checks++;
        if (dpo !== 4'hC) begin
            n_fail++;
            $display("FAIL wr_rd_dpo2 dpo=%h required C", dpo);
        end
        dpra = 5'd1; a = 5'd1;
        tick();
        n_checks++;
        if (dpo !== 4'hA || spo !== 4'hA) begin
            n_fail++;
            $display("FAIL wr_rd_addr1 spo=%h dpo=%h required A/A", spo, dpo);
        end
    endtask

    task automatic test_rbw_port_a;
        we = 1'b1; a = 5'd3; di = 4'hF;
        tick();
        n_checks++;
        if (spo !== 4'h0) begin
            n_fail++;
            $display("FAIL rbw_a_old spo=%h required 0", spo);
        end
        we = 1'b0;
        tick();
        n_checks++;
        if (spo !== 4'hF) begin
            n_fail++;
            $display("FAIL rbw_a_new spo=%h required F", spo);
        end
    endtask

    task automatic test_collision_b;
        we = 1'b1; a = 5'd5; di = 4'h3;
        tick();
        dpra = 5'd5; di = 4'h9;
        tick();
        n_checks++;
        if (dpo !== 4'h3 || spo !== 4'h3) begin
            n_fail++;
            $display("FAIL coll_b_old spo=%h dpo=%h required 3/3", spo, dpo);
        end
        we = 1'b0;
        tick();
        n_checks++;
        if (dpo !== 4'h9) begin
            n_fail++;
            $display("FAIL coll_b_new dpo=%h required 9", dpo);
        end
    endtask

    task automatic test_write_disabled;
        we = 1'b0; a = 5'd7; di = 4'h6; dpra = 5'd7;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (spo !== 4'h0 || dpo !== 4'h0) begin
                n_fail++;
                $display("FAIL we_off_%0d spo=%h dpo=%h required 0/0", k, spo, dpo);
            end
        end
    endtask

    task automatic test_sweep;
        logic [3:0] ea;
        logic [3:0] eb;
        we = 1'b1;
        for (int i = 0; i < 32; i++) begin
            a = 5'(i);
            di = 4'(i ^ 5);
            tick();
        end
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            a = 5'(i);
            dpra = 5'(31 - i);
            tick();
            ea = 4'(i ^ 5);
            eb = 4'((31 - i) ^ 5);
            n_checks++;
            if (spo !== ea || dpo !== eb) begin
                n_fail++;
                $display("FAIL sweep_%0d spo=%h dpo=%h required %h/%h",
                         i, spo, dpo, ea, eb);
            end
        end
        a = 5'd0; dpra = 5'd0; we = 1'b1; di = 4'h0;
        #2;
        n_checks++;
        if (spo !== 4'hA || dpo !== 4'h5) begin
            n_fail++;
            $display("FAIL no_comb_path spo=%h dpo=%h required A/5", spo, dpo);
        end
        we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_rbw_port_a();
        test_collision_b();
        test_write_disabled();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
